oc_dispatch_xbar: RTL and testbench
===================================

Name: oc_dispatch_xbar

Overview:
Parametrised, registered dispatch crossbar between the operand collectors (OCs) and the execution units (EUs, e.g. ALU and MEM). Each EU has its own one-hot grant vector that selects one OC's operand-plus-control bundle. The selected bundle is captured into a per-EU output register and presented with a valid/ready handshake. The block pulses a release back to the granted OC, detects grant conflicts, and keeps per-EU dispatch counts.

Parameters:
NUM_OC, 4, number of operand collector slots (≥2)
NUM_EU, 2, number of execution unit ports (EU0=ALU, EU1=MEM by convention)
DATA_W, 256, width of each source-operand vector (8 lanes × 32b)
CTRL_W, 80, width of packed control bundle (instr, imme, aluop, flags, scb id, mask, dst)
CNT_W, 16, width of per-EU dispatch counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
oc_valid  in  NUM_OC  OC slot i holds a fully collected instruction
oc_src0  in  NUM_OC*DATA_W  operand 0 of each OC, slot i at [i*DATA_W +: DATA_W]
oc_src1  in  NUM_OC*DATA_W  operand 1 of each OC, same packing
oc_ctrl  in  NUM_OC*CTRL_W  control bundle of each OC
eu_grant  in  NUM_EU*NUM_OC  per-EU grant vector, EU e at [e*NUM_OC +: NUM_OC]; expected one-hot or zero
eu_ready  in  NUM_EU  EU e can consume its output register this cycle
eu_valid  out  NUM_EU  output register of EU e holds an instruction
eu_src0  out  NUM_EU*DATA_W  registered operand 0 per EU
eu_src1  out  NUM_EU*DATA_W  registered operand 1 per EU
eu_ctrl  out  NUM_EU*CTRL_W  registered control per EU
oc_release  out  NUM_OC  combinational pulse: OC i dispatched this cycle, free the slot
eu_stall  out  NUM_EU  EU e had a valid grant that was blocked by a full output register
err_status  out  3  sticky: [0] multi-hot grant, [1] same OC granted to two EUs, [2] grant to an invalid OC
err_clr  in  1  clears err_status (synchronous)
dispatch_cnt  out  NUM_EU*CNT_W  per-EU accepted-dispatch counter, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - eu_valid, eu_src0/src1/ctrl, err_status, dispatch_cnt.
  - Reset mid-transfer drops the in-flight bundle; no oc_release is issued in the reset cycle.
- Combinational outputs (oc_release, eu_stall) are forced to 0 while rst_n=0.
- can_load[e] = !eu_valid[e] | eu_ready[e]. This gives full throughput: one dispatch per EU per cycle.
- Grant qualification per EU e, with g = its grant slice:
  - g==0: no action.
  - g multi-hot: no dispatch; set err_status[0].
  - g one-hot at i and oc_valid[i]=0: no dispatch; set err_status[2].
  - g one-hot at i, oc_valid[i]=1: candidate.
- Conflict rule: if candidates on EUs e<f name the same OC i, the lowest-index EU keeps it, f is suppressed, and err_status[1] is set.
- A candidate with can_load[e]=0 does not dispatch and asserts eu_stall[e].
- Dispatch, at the clk edge, when a candidate is not suppressed and can_load[e]=1:
  - eu_src0/src1/ctrl[e] capture OC i; eu_valid[e] becomes 1.
  - oc_release[i]=1 in that same cycle.
  - dispatch_cnt[e] increments, saturating at all-ones.
- Latency: grant in cycle N → eu_valid in cycle N+1.
- If eu_ready[e]=1 and there is no dispatch, eu_valid[e] becomes 0. Output data is held (not cleared) when invalid.
- Output register contents are stable while eu_valid=1 and eu_ready=0.
- oc_release is at most one pulse per OC per cycle, even if two EUs grant it.
- err_status bits are sticky. When err_clr and a new error occur in the same cycle, the new error wins (the bit stays set).
- eu_ready while eu_valid=0 is ignored.

Test Plan:
1. Reset: hold rst_n=0 with all oc_valid=1 and grants active → all outputs 0, no oc_release. Release reset → first dispatch appears one cycle after the first grant.
2. Basic routing: oc_valid=4'b1111; EU0 grant=4'b0100, EU1 grant=4'b0001, both ready → next cycle EU0 holds OC2's data, EU1 holds OC0's data; oc_release=4'b0101; each dispatch_cnt=1.
3. Backpressure: EU1 valid with eu_ready[1]=0 and a new grant to OC3 → eu_stall[1]=1, oc_release[3]=0, output unchanged. Raise eu_ready[1] → OC3 is captured the same cycle, no bubble.
4. Conflict: both EUs grant OC1 (4'b0010) → only EU0 dispatches, oc_release=4'b0010, err_status[1]=1. Pulse err_clr → err_status=0.
5. Illegal grants: EU0 grant=4'b0110 → no dispatch, err_status[0]=1. EU1 grant to an OC with oc_valid=0 → err_status[2]=1, eu_valid[1] unchanged.
6. Counter saturation, with CNT_W=4: 20 back-to-back EU0 dispatches with eu_ready=1 → dispatch_cnt[0] stops at 15, and throughput stays one dispatch per cycle.

Source files
------------

// File: rtl/oc_dispatch_xbar.sv
`default_nettype none
// ============================================================================
// Module   : oc_dispatch_xbar
// Purpose  : Registered dispatch crossbar from operand collectors to execution
//            units. Each EU selects one OC through its one-hot grant slice.
//            The selected bundle is captured into a per-EU output register
//            with a valid/ready handshake. Releases are pulsed back to the OC,
//            grant conflicts are flagged, and accepted dispatches are counted.
// Revision : 1.0 - initial release
// ============================================================================
module oc_dispatch_xbar #(
  parameter int NUM_OC = 4,
  parameter int NUM_EU = 2,
  parameter int DATA_W = 256,
  parameter int CTRL_W = 80,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_OC-1:0]        oc_valid,
  input  logic [NUM_OC*DATA_W-1:0] oc_src0,
  input  logic [NUM_OC*DATA_W-1:0] oc_src1,
  input  logic [NUM_OC*CTRL_W-1:0] oc_ctrl,
  input  logic [NUM_EU*NUM_OC-1:0] eu_grant,
  input  logic [NUM_EU-1:0]        eu_ready,
  output logic [NUM_EU-1:0]        eu_valid,
  output logic [NUM_EU*DATA_W-1:0] eu_src0,
  output logic [NUM_EU*DATA_W-1:0] eu_src1,
  output logic [NUM_EU*CTRL_W-1:0] eu_ctrl,
  output logic [NUM_OC-1:0]        oc_release,
  output logic [NUM_EU-1:0]        eu_stall,
  output logic [2:0]               err_status,
  input  logic                     err_clr,
  output logic [NUM_EU*CNT_W-1:0]  dispatch_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-EU qualification results
  logic [NUM_OC-1:0] w_grant [NUM_EU];
  logic [NUM_EU-1:0] w_can_load;
  logic [NUM_EU-1:0] w_multi;
  logic [NUM_EU-1:0] w_inval;
  logic [NUM_EU-1:0] w_cand;
  logic [NUM_EU-1:0] w_sup;
  logic [NUM_EU-1:0] w_disp;
  logic [NUM_EU-1:0] w_stall;
  logic [NUM_OC-1:0] w_release;
  logic [2:0]        w_err_set;
  logic [DATA_W-1:0] w_sel_src0 [NUM_EU];
  logic [DATA_W-1:0] w_sel_src1 [NUM_EU];
  logic [CTRL_W-1:0] w_sel_ctrl [NUM_EU];

  // Output registers and status
  logic [NUM_EU-1:0] r_valid;
  logic [DATA_W-1:0] r_src0 [NUM_EU];
  logic [DATA_W-1:0] r_src1 [NUM_EU];
  logic [CTRL_W-1:0] r_ctrl [NUM_EU];
  logic [CNT_W-1:0]  r_cnt  [NUM_EU];
  logic [2:0]        r_err;

  // Grant qualification, conflict resolution, bundle selection and release
  always_comb begin
    w_can_load = '0;
    w_multi    = '0;
    w_inval    = '0;
    w_cand     = '0;
    w_sup      = '0;
    w_disp     = '0;
    w_stall    = '0;
    w_release  = '0;
    w_err_set  = '0;
    for (int e = 0; e < NUM_EU; e++) begin
      w_grant[e]    = eu_grant[e*NUM_OC +: NUM_OC];
      w_sel_src0[e] = '0;
      w_sel_src1[e] = '0;
      w_sel_ctrl[e] = '0;
    end

    for (int e = 0; e < NUM_EU; e++) begin
      w_can_load[e] = !r_valid[e] || eu_ready[e];
      w_multi[e]    = ($countones(w_grant[e]) > 1);
      w_cand[e]     = ($countones(w_grant[e]) == 1) && (|(w_grant[e] & oc_valid));
      w_inval[e]    = ($countones(w_grant[e]) == 1) && !(|(w_grant[e] & oc_valid));
      // AND-OR mux; only meaningful when the grant is one-hot
      for (int i = 0; i < NUM_OC; i++) begin
        if (w_grant[e][i]) begin
          w_sel_src0[e] = w_sel_src0[e] | oc_src0[i*DATA_W +: DATA_W];
          w_sel_src1[e] = w_sel_src1[e] | oc_src1[i*DATA_W +: DATA_W];
          w_sel_ctrl[e] = w_sel_ctrl[e] | oc_ctrl[i*CTRL_W +: CTRL_W];
        end
      end
    end

    // A lower-index EU naming the same OC wins; the higher one is suppressed
    for (int f = 1; f < NUM_EU; f++) begin
      for (int e = 0; e < f; e++) begin
        if (w_cand[e] && w_cand[f] && (w_grant[e] == w_grant[f])) begin
          w_sup[f] = 1'b1;
        end
      end
    end

    // Gating with rst_n keeps release/stall quiet during reset
    for (int e = 0; e < NUM_EU; e++) begin
      w_disp[e]  = rst_n && w_cand[e] && !w_sup[e] && w_can_load[e];
      w_stall[e] = rst_n && w_cand[e] && !w_sup[e] && !w_can_load[e];
      if (w_disp[e]) begin
        w_release = w_release | w_grant[e];
      end
    end

    w_err_set[0] = |w_multi;
    w_err_set[1] = |w_sup;
    w_err_set[2] = |w_inval;
  end

  // Per-EU output registers and saturating dispatch counters
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_EU; e++) begin
      if (!rst_n) begin
        r_valid[e] <= 1'b0;
        r_src0[e]  <= '0;
        r_src1[e]  <= '0;
        r_ctrl[e]  <= '0;
        r_cnt[e]   <= '0;
      end else if (w_disp[e]) begin
        r_valid[e] <= 1'b1;
        r_src0[e]  <= w_sel_src0[e];
        r_src1[e]  <= w_sel_src1[e];
        r_ctrl[e]  <= w_sel_ctrl[e];
        if (r_cnt[e] != c_cnt_max) begin
          r_cnt[e] <= r_cnt[e] + c_cnt_one;
        end
      end else if (eu_ready[e]) begin
        r_valid[e] <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps its bit set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
    end
  end

  for (genvar e = 0; e < NUM_EU; e++) begin : g_pack
    assign eu_src0[e*DATA_W +: DATA_W]     = r_src0[e];
    assign eu_src1[e*DATA_W +: DATA_W]     = r_src1[e];
    assign eu_ctrl[e*CTRL_W +: CTRL_W]     = r_ctrl[e];
    assign dispatch_cnt[e*CNT_W +: CNT_W]  = r_cnt[e];
  end

  assign eu_valid   = r_valid;
  assign oc_release = w_release;
  assign eu_stall   = w_stall;
  assign err_status = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oc_dispatch_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_oc_dispatch_xbar
// Purpose  : Table-driven self-checking bench for oc_dispatch_xbar
//            (4 OCs, 2 EUs, 64-bit data, 16-bit control, 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oc_dispatch_xbar;

  localparam int NOC = 4;
  localparam int NEU = 2;
  localparam int DW  = 64;
  localparam int CW  = 16;
  localparam int NW  = 4;

  logic              clk;
  logic              rst_n;
  logic [NOC-1:0]    oc_valid;
  logic [NOC*DW-1:0] oc_src0;
  logic [NOC*DW-1:0] oc_src1;
  logic [NOC*CW-1:0] oc_ctrl;
  logic [NEU*NOC-1:0] eu_grant;
  logic [NEU-1:0]    eu_ready;
  logic [NEU-1:0]    eu_valid;
  logic [NEU*DW-1:0] eu_src0;
  logic [NEU*DW-1:0] eu_src1;
  logic [NEU*CW-1:0] eu_ctrl;
  logic [NOC-1:0]    oc_release;
  logic [NEU-1:0]    eu_stall;
  logic [2:0]        err_status;
  logic              err_clr;
  logic [NEU*NW-1:0] dispatch_cnt;

  oc_dispatch_xbar #(
    .NUM_OC(NOC), .NUM_EU(NEU), .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oc_valid(oc_valid), .oc_src0(oc_src0),
    .oc_src1(oc_src1), .oc_ctrl(oc_ctrl), .eu_grant(eu_grant),
    .eu_ready(eu_ready), .eu_valid(eu_valid), .eu_src0(eu_src0),
    .eu_src1(eu_src1), .eu_ctrl(eu_ctrl), .oc_release(oc_release),
    .eu_stall(eu_stall), .err_status(err_status), .err_clr(err_clr),
    .dispatch_cnt(dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle: inputs, same-cycle combinational expectations,
  // and what the registers must hold after the edge.
  // x_d*: -1 = register holds, -2 = cleared by reset, >=0 = OC captured
  typedef struct {
    logic       rst_n;
    logic [3:0] ocv;
    logic [3:0] g0;
    logic [3:0] g1;
    logic [1:0] rdy;
    logic       clr;
    logic [3:0] x_rel;
    logic [1:0] x_stall;
    int         x_d0;
    int         x_d1;
    logic [1:0] x_valid;
    logic [2:0] x_err;
    logic [3:0] x_c0;
    logic [3:0] x_c1;
  } vec_t;

  typedef struct {
    logic [1:0]         valid;
    logic [2:0]         err;
    logic [1:0][3:0]    cnt;
    logic [1:0][DW-1:0] s0;
    logic [1:0][DW-1:0] s1;
    logic [1:0][CW-1:0] ct;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  logic [1:0][DW-1:0] m_s0;
  logic [1:0][DW-1:0] m_s1;
  logic [1:0][CW-1:0] m_ct;

  function automatic logic [DW-1:0] mk0(input int t, input int i);
    return {32'hA000_0000 + 32'(t), 32'h0000_0100 + 32'(i)};
  endfunction
  function automatic logic [DW-1:0] mk1(input int t, input int i);
    return {32'h5B00_0000 + 32'(t), 32'h0000_0E00 + 32'(i)};
  endfunction
  function automatic logic [CW-1:0] mkc(input int t, input int i);
    return {8'(t), 8'h50 + 8'(i)};
  endfunction

  task automatic add(input logic r, input logic [3:0] ov, g0, g1,
                     input logic [1:0] rdy, input logic clr,
                     input logic [3:0] rel, input logic [1:0] st,
                     input int d0, d1, input logic [1:0] vld,
                     input logic [2:0] err, input logic [3:0] c0, c1);
    vec_t v;
    v.rst_n = r; v.ocv = ov; v.g0 = g0; v.g1 = g1; v.rdy = rdy; v.clr = clr;
    v.x_rel = rel; v.x_stall = st; v.x_d0 = d0; v.x_d1 = d1;
    v.x_valid = vld; v.x_err = err; v.x_c0 = c0; v.x_c1 = c1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @vec%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic upd_model(input int e, input int d, input int t);
    if (d == -2) begin
      m_s0[e] = '0; m_s1[e] = '0; m_ct[e] = '0;
    end else if (d >= 0) begin
      m_s0[e] = mk0(t, d); m_s1[e] = mk1(t, d); m_ct[e] = mkc(t, d);
    end
  endtask

  initial begin
    exp_t x;
    n_chk = 0;
    n_fail = 0;
    m_s0 = '0; m_s1 = '0; m_ct = '0;
    rst_n = 1'b0; oc_valid = '0; oc_src0 = '0; oc_src1 = '0; oc_ctrl = '0;
    eu_grant = '0; eu_ready = '0; err_clr = 1'b0;

    //   rst ocv    g0      g1      rdy    clr  rel     stall  d0  d1  valid  err     c0 c1
    // reset with grants active: nothing leaves, everything clears
    add(0, 4'hF, 4'b0100, 4'b0001, 2'b11, 0, 4'b0000, 2'b00, -2, -2, 2'b00, 3'b000, 0, 0);
    add(0, 4'hF, 4'b0100, 4'b0001, 2'b11, 0, 4'b0000, 2'b00, -2, -2, 2'b00, 3'b000, 0, 0);
    // basic routing: EU0<-OC2, EU1<-OC0
    add(1, 4'hF, 4'b0100, 4'b0001, 2'b11, 0, 4'b0101, 2'b00,  2,  0, 2'b11, 3'b000, 1, 1);
    // EU1 backpressured with a grant to OC3; EU0 drains
    add(1, 4'hF, 4'b0000, 4'b1000, 2'b01, 0, 4'b0000, 2'b10, -1, -1, 2'b10, 3'b000, 1, 1);
    add(1, 4'hF, 4'b0000, 4'b1000, 2'b00, 0, 4'b0000, 2'b10, -1, -1, 2'b10, 3'b000, 1, 1);
    // ready rises: OC3 captured in the same cycle
    add(1, 4'hF, 4'b0000, 4'b1000, 2'b10, 0, 4'b1000, 2'b00, -1,  3, 2'b10, 3'b000, 1, 2);
    // conflict on OC1: EU0 wins
    add(1, 4'hF, 4'b0010, 4'b0010, 2'b11, 0, 4'b0010, 2'b00,  1, -1, 2'b01, 3'b010, 2, 2);
    add(1, 4'hF, 4'b0000, 4'b0000, 2'b11, 1, 4'b0000, 2'b00, -1, -1, 2'b00, 3'b000, 2, 2);
    // multi-hot grant
    add(1, 4'hF, 4'b0110, 4'b0000, 2'b11, 0, 4'b0000, 2'b00, -1, -1, 2'b00, 3'b001, 2, 2);
    // load EU1, then grant an invalid OC while it is held
    add(1, 4'hF, 4'b0000, 4'b0100, 2'b00, 0, 4'b0100, 2'b00, -1,  2, 2'b10, 3'b001, 2, 3);
    add(1, 4'hB, 4'b0000, 4'b0100, 2'b00, 0, 4'b0000, 2'b00, -1, -1, 2'b10, 3'b101, 2, 3);
    // clear and a new multi-hot error together: new error survives
    add(1, 4'hF, 4'b1100, 4'b0000, 2'b11, 1, 4'b0000, 2'b00, -1, -1, 2'b00, 3'b001, 2, 3);
    // partially valid OCs, both EUs dispatch
    add(1, 4'h5, 4'b0001, 4'b0100, 2'b11, 0, 4'b0101, 2'b00,  0,  2, 2'b11, 3'b001, 3, 4);
    add(1, 4'hF, 4'b0000, 4'b0000, 2'b11, 1, 4'b0000, 2'b00, -1, -1, 2'b00, 3'b000, 3, 4);
    // 20 back-to-back EU0 dispatches: counter saturates at 15
    for (int k = 1; k <= 20; k++) begin
      add(1, 4'hF, 4'(1 << (k % 4)), 4'b0000, 2'b11, 0, 4'(1 << (k % 4)), 2'b00,
          k % 4, -1, 2'b01, 3'b000, 4'((3 + k > 15) ? 15 : 3 + k), 4'd4);
    end
    // reset mid-transfer, then the first grant after reset
    add(0, 4'hF, 4'b0001, 4'b0000, 2'b11, 0, 4'b0000, 2'b00, -2, -2, 2'b00, 3'b000, 0, 0);
    add(1, 4'hF, 4'b0010, 4'b0000, 2'b11, 0, 4'b0010, 2'b00,  1, -1, 2'b01, 3'b000, 1, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst_n    = vecs[k].rst_n;
      oc_valid = vecs[k].ocv;
      eu_grant = {vecs[k].g1, vecs[k].g0};
      eu_ready = vecs[k].rdy;
      err_clr  = vecs[k].clr;
      for (int i = 0; i < NOC; i++) begin
        oc_src0[i*DW +: DW] = mk0(k, i);
        oc_src1[i*DW +: DW] = mk1(k, i);
        oc_ctrl[i*CW +: CW] = mkc(k, i);
      end
      upd_model(0, vecs[k].x_d0, k);
      upd_model(1, vecs[k].x_d1, k);
      x.valid = vecs[k].x_valid;
      x.err   = vecs[k].x_err;
      x.cnt   = {vecs[k].x_c1, vecs[k].x_c0};
      x.s0 = m_s0; x.s1 = m_s1; x.ct = m_ct;
      sb.push_back(x);
      #1;
      chk("oc_release", k, 64'(oc_release), 64'(vecs[k].x_rel));
      chk("eu_stall", k, 64'(eu_stall), 64'(vecs[k].x_stall));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard @vec%0d: got empty queue expected entry", k);
      end else begin
        x = sb.pop_front();
        chk("eu_valid", k, 64'(eu_valid), 64'(x.valid));
        chk("err_status", k, 64'(err_status), 64'(x.err));
        for (int e = 0; e < NEU; e++) begin
          chk($sformatf("dispatch_cnt%0d", e), k, 64'(dispatch_cnt[e*NW +: NW]), 64'(x.cnt[e]));
          chk($sformatf("eu_src0_%0d", e), k, eu_src0[e*DW +: DW], x.s0[e]);
          chk($sformatf("eu_src1_%0d", e), k, eu_src1[e*DW +: DW], x.s1[e]);
          chk($sformatf("eu_ctrl%0d", e), k, 64'(eu_ctrl[e*CW +: CW]), 64'(x.ct[e]));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
